// File: rtl/board_seq_pkg.sv
// Shared types and constants for the board reset sequencer.
// Optional heartbeat LED is enabled with BOARD_SEQ_HEARTBEAT_EN.
package board_seq_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WAIT_PLL = 4'd1,
    MEM_RST  = 4'd2,
    WAIT_CAL = 4'd3,
    KDELAY   = 4'd4,
    RUN      = 4'd5,
    FAIL     = 4'd6
  } seq_state_e;

  localparam int LED_STATE_LSB = 0;
  localparam int LED_ERR       = 4;
  localparam int LED_CAL_OK    = 5;
  localparam int LED_PLL       = 6;
  localparam int LED_HB        = 7;

  localparam int N_MEM_DEF = 6;

  localparam int DDR3A  = 0;
  localparam int DDR3B  = 1;
  localparam int QDRIIA = 2;
  localparam int QDRIIB = 3;
  localparam int QDRIIC = 4;
  localparam int QDRIID = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/board_seq_sync.sv
// Parameterised-width two-flop synchronizer, async active-low reset.
// Optional heartbeat LED in the top is enabled with BOARD_SEQ_HEARTBEAT_EN.
module board_seq_sync #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/board_reset_sequencer.sv
// Sequenced board bring-up: PERST/PLL wait, memory calibration with retry.
// Define BOARD_SEQ_HEARTBEAT_EN to add the heartbeat blink on leds[7].
module board_reset_sequencer
  import board_seq_pkg::*;
#(
  parameter int N_MEM        = N_MEM_DEF,
  parameter int HOLD_CYCLES  = 256,
  parameter int CAL_TIMEOUT  = 50000000,
  parameter int KERNEL_DELAY = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pcie_npor,
  input  logic             pll_locked,
  input  logic [N_MEM-1:0] mem_enable,
  input  logic [N_MEM-1:0] mem_cal_success,
  input  logic [N_MEM-1:0] mem_cal_fail,
  output logic [N_MEM-1:0] mem_soft_reset_n,
  output logic             kernel_resetn,
  output logic             seq_ready,
  output logic             seq_error,
  output logic [1:0]       retry_count,
  output logic [7:0]       leds
);

  localparam int CMAX = max3(HOLD_CYCLES, CAL_TIMEOUT, KERNEL_DELAY);
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int HE   = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int CE   = (CAL_TIMEOUT > 0) ? CAL_TIMEOUT - 1 : 0;
  localparam int KE   = (KERNEL_DELAY > 0) ? KERNEL_DELAY - 1 : 0;
  localparam logic [CW-1:0] HOLD_END = CW'(HE);
  localparam logic [CW-1:0] CAL_END  = CW'(CE);
  localparam logic [CW-1:0] KD_END   = CW'(KE);
  localparam logic [1:0] RETRY_MAX =
    2'((MAX_RETRY > 3) ? 3 : MAX_RETRY);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [1:0]       r_retry;
  logic [1:0]       w_retry_nxt;
  logic [N_MEM-1:0] r_mem_n;
  logic [N_MEM-1:0] w_mem_nxt;
  logic             r_krn;
  logic             r_rdy;
  logic             r_err;
  logic [7:0]       r_leds;
  logic [7:0]       w_leds_nxt;
  logic             w_hb;

  logic [1:0]         w_ctl_s;
  logic [2*N_MEM-1:0] w_cal_s;
  logic               w_npor_s;
  logic               w_pll_s;
  logic [N_MEM-1:0]   w_succ_s;
  logic [N_MEM-1:0]   w_fail_s;
  logic               w_all_ok;
  logic               w_any_fail;

  board_seq_sync #(.W(2)) u_sync_ctl (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_d     ({pcie_npor, pll_locked}),
    .o_q     (w_ctl_s)
  );

  board_seq_sync #(.W(2*N_MEM)) u_sync_cal (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_d     ({mem_cal_success, mem_cal_fail}),
    .o_q     (w_cal_s)
  );

  assign w_npor_s   = w_ctl_s[1];
  assign w_pll_s    = w_ctl_s[0];
  assign w_succ_s   = w_cal_s[2*N_MEM-1:N_MEM];
  assign w_fail_s   = w_cal_s[N_MEM-1:0];
  assign w_all_ok   = &(~mem_enable | w_succ_s);
  assign w_any_fail = |(mem_enable & w_fail_s);

  // FAIL is sticky against PLL loss; only PERST or resetn clears it.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    if (!w_npor_s) begin
      w_state_nxt = IDLE;
      w_retry_nxt = 2'd0;
    end else if (!w_pll_s &&
                 !(r_state inside {IDLE, WAIT_PLL, FAIL})) begin
      w_state_nxt = WAIT_PLL;
    end else begin
      unique case (r_state)
        IDLE:     w_state_nxt = WAIT_PLL;
        WAIT_PLL: if (w_pll_s) w_state_nxt = MEM_RST;
        MEM_RST:  if (r_cnt >= HOLD_END) w_state_nxt = WAIT_CAL;
        WAIT_CAL: begin
          if (w_any_fail || r_cnt >= CAL_END) begin
            if (r_retry < RETRY_MAX) begin
              w_retry_nxt = r_retry + 2'd1;
              w_state_nxt = MEM_RST;
            end else begin
              w_state_nxt = FAIL;
            end
          end else if (w_all_ok) begin
            w_state_nxt = KDELAY;
          end
        end
        KDELAY:   if (r_cnt >= KD_END) w_state_nxt = RUN;
        RUN:      if (!w_all_ok || w_any_fail) w_state_nxt = FAIL;
        FAIL:     w_state_nxt = FAIL;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    if (w_state_nxt == r_state)
      w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
  end

  always_comb begin
    w_mem_nxt = '0;
    if (w_state_nxt inside {WAIT_CAL, KDELAY, RUN})
      w_mem_nxt = mem_enable;
  end

  always_comb begin
    w_leds_nxt = 8'h00;
    w_leds_nxt[LED_STATE_LSB +: 4] = w_state_nxt;
    w_leds_nxt[LED_ERR]    = (w_state_nxt == FAIL);
    w_leds_nxt[LED_CAL_OK] = w_all_ok;
    w_leds_nxt[LED_PLL]    = w_pll_s;
    w_leds_nxt[LED_HB]     = w_hb;
  end

`ifdef BOARD_SEQ_HEARTBEAT_EN
  logic [23:0] r_hb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_hb <= '0;
    else         r_hb <= r_hb + 24'd1;
  end

  assign w_hb = (w_state_nxt == FAIL) ? r_hb[21] : r_hb[23];
`else
  assign w_hb = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_retry <= 2'd0;
      r_mem_n <= '0;
      r_krn   <= 1'b0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      r_leds  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
      r_mem_n <= w_mem_nxt;
      r_krn   <= (w_state_nxt == RUN);
      r_rdy   <= (w_state_nxt == RUN);
      r_err   <= (w_state_nxt == FAIL);
      r_leds  <= w_leds_nxt;
    end
  end

  assign mem_soft_reset_n = r_mem_n;
  assign kernel_resetn    = r_krn;
  assign seq_ready        = r_rdy;
  assign seq_error        = r_err;
  assign retry_count      = r_retry;
  assign leds             = r_leds;

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Scoreboard bench: expected state transitions are queued by the stimulus
// and popped by a monitor whenever the reported state code changes.
module tb_board_reset_sequencer;
  import board_seq_pkg::*;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_WPLL = 4'd1;
  localparam logic [3:0] S_MRST = 4'd2;
  localparam logic [3:0] S_WCAL = 4'd3;
  localparam logic [3:0] S_KDLY = 4'd4;
  localparam logic [3:0] S_RUN  = 4'd5;
  localparam logic [3:0] S_FAIL = 4'd6;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pcie_npor;
  logic       pll_locked;
  logic [5:0] mem_enable;
  logic [5:0] mem_cal_success;
  logic [5:0] mem_cal_fail;
  logic [5:0] mem_soft_reset_n;
  logic       kernel_resetn;
  logic       seq_ready;
  logic       seq_error;
  logic [1:0] retry_count;
  logic [7:0] leds;

  typedef struct {
    logic [3:0] st;
    logic [5:0] mem;
    logic       krn;
    logic       rdy;
    logic       err;
    logic [1:0] rty;
    int         dur;
    int         ld;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [3:0] last_st = 4'd0;
  int   dur = 0;
  int   ntr = 0;

  always #5 clk = ~clk;

  board_reset_sequencer #(
    .N_MEM        (6),
    .HOLD_CYCLES  (16),
    .CAL_TIMEOUT  (100),
    .KERNEL_DELAY (8),
    .MAX_RETRY    (2)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .pcie_npor        (pcie_npor),
    .pll_locked       (pll_locked),
    .mem_enable       (mem_enable),
    .mem_cal_success  (mem_cal_success),
    .mem_cal_fail     (mem_cal_fail),
    .mem_soft_reset_n (mem_soft_reset_n),
    .kernel_resetn    (kernel_resetn),
    .seq_ready        (seq_ready),
    .seq_error        (seq_error),
    .retry_count      (retry_count),
    .leds             (leds)
  );

  task automatic push(input logic [3:0] st, input logic [5:0] mem,
                      input logic [1:0] rty, input int d, input int ld);
    exp_t e;
    e.st  = st;
    e.mem = mem;
    e.krn = (st == S_RUN);
    e.rdy = (st == S_RUN);
    e.err = (st == S_FAIL);
    e.rty = rty;
    e.dur = d;
    e.ld  = ld;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (leds[3:0] != last_st) begin
        exp_t e;
        bit   ok;
        checks++;
        ntr++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL trans%0d: unexpected state %0d", ntr, leds[3:0]);
        end else begin
          e  = q.pop_front();
          ok = (leds[3:0] == e.st) && (mem_soft_reset_n == e.mem) &&
               (kernel_resetn == e.krn) && (seq_ready == e.rdy) &&
               (seq_error == e.err) && (leds[4] == e.err) &&
               (retry_count == e.rty) &&
               (e.dur < 0 || dur == e.dur) &&
               (e.ld < 0 || leds == e.ld[7:0]);
          if (!ok) begin
            errors++;
            $display({"FAIL trans%0d: got st=%0d mem=%h krn=%b rdy=%b",
                      " err=%b rty=%0d dur=%0d leds=%h; want st=%0d",
                      " mem=%h krn=%b rdy=%b err=%b rty=%0d dur=%0d",
                      " leds=%0d"},
                     ntr, leds[3:0], mem_soft_reset_n, kernel_resetn,
                     seq_ready, seq_error, retry_count, dur, leds,
                     e.st, e.mem, e.krn, e.rdy, e.err, e.rty, e.dur,
                     e.ld);
          end
        end
        last_st = leds[3:0];
        dur = 1;
      end else begin
        dur++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_st(input logic [3:0] s, input int budget);
    int n = 0;
    while (leds[3:0] != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (leds[3:0] != s) begin
      errors++;
      $display("FAIL wait_state: got %0d want %0d", leds[3:0], s);
    end
  endtask

  task automatic wait_mem(input logic [5:0] v, input int budget);
    int n = 0;
    while (mem_soft_reset_n != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_soft_reset_n != v) begin
      errors++;
      $display("FAIL wait_mem: got %h want %h", mem_soft_reset_n, v);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d transitions missing, got 0 want 0",
               q.size());
      q.delete();
    end
  endtask

  task automatic to_idle(input logic [1:0] rty_was);
    push(S_IDLE, 6'h00, 2'd0, -1, -1);
    pcie_npor       = 1'b0;
    mem_cal_success = 6'h00;
    mem_cal_fail    = 6'h00;
    drain(20);
    chk("retry_cleared_from", {30'd0, rty_was}, {30'd0, rty_was});
  endtask

  logic [5:0] all_m;
  logic [5:0] ddr_m;

  initial begin
    all_m = 6'((1 << DDR3A) | (1 << DDR3B) | (1 << QDRIIA) |
               (1 << QDRIIB) | (1 << QDRIIC) | (1 << QDRIID));
    ddr_m = 6'((1 << DDR3A) | (1 << DDR3B));
    resetn          = 1'b1;
    pcie_npor       = 1'b0;
    pll_locked      = 1'b0;
    mem_enable      = all_m;
    mem_cal_success = 6'h00;
    mem_cal_fail    = 6'h00;
    #2 resetn = 1'b0;
    #1;
    chk("rst_mem_n", {26'd0, mem_soft_reset_n}, 32'h0);
    chk("rst_krn", {31'd0, kernel_resetn}, 32'h0);
    chk("rst_ready", {31'd0, seq_ready}, 32'h0);
    chk("rst_error", {31'd0, seq_error}, 32'h0);
    chk("rst_retry", {30'd0, retry_count}, 32'h0);
    chk("rst_leds", {24'd0, leds}, 32'h0);
    mon_en = 1'b1;
    cyc(3);
    resetn = 1'b1;
    cyc(3);

    // 1: nominal bring-up, all six interfaces
    push(S_WPLL, 6'h00, 2'd0, -1, -1);
    push(S_MRST, 6'h00, 2'd0, -1, -1);
    push(S_WCAL, all_m, 2'd0, 16, -1);
    push(S_KDLY, all_m, 2'd0, -1, -1);
    push(S_RUN,  all_m, 2'd0, 8, 8'h65);
    pcie_npor = 1'b1;
    wait_st(S_WPLL, 20);
    cyc(4);
    pll_locked = 1'b1;
    wait_mem(all_m, 60);
    cyc(20);
    mem_cal_success = all_m;
    drain(40);

    // 2: only the DDR3 interfaces populated
    push(S_IDLE, 6'h00, 2'd0, -1, -1);
    pcie_npor       = 1'b0;
    mem_cal_success = 6'h00;
    drain(20);
    mem_enable = ddr_m;
    push(S_WPLL, 6'h00, 2'd0, -1, -1);
    push(S_MRST, 6'h00, 2'd0, 1, -1);
    push(S_WCAL, ddr_m, 2'd0, 16, -1);
    push(S_KDLY, ddr_m, 2'd0, -1, -1);
    push(S_RUN,  ddr_m, 2'd0, 8, 8'h65);
    pcie_npor = 1'b1;
    wait_mem(ddr_m, 60);
    cyc(5);
    mem_cal_success = ddr_m;
    drain(40);

    // 3: QDRII A fails first attempt, succeeds on retry
    push(S_IDLE, 6'h00, 2'd0, -1, -1);
    pcie_npor       = 1'b0;
    mem_cal_success = 6'h00;
    drain(20);
    mem_enable = all_m;
    push(S_WPLL, 6'h00, 2'd0, -1, -1);
    push(S_MRST, 6'h00, 2'd0, 1, -1);
    push(S_WCAL, all_m, 2'd0, 16, -1);
    push(S_MRST, 6'h00, 2'd1, -1, -1);
    push(S_WCAL, all_m, 2'd1, 16, -1);
    push(S_KDLY, all_m, 2'd1, -1, -1);
    push(S_RUN,  all_m, 2'd1, 8, 8'h65);
    pcie_npor = 1'b1;
    wait_mem(all_m, 60);
    cyc(5);
    mem_cal_fail = 6'(1 << QDRIIA);
    wait_mem(6'h00, 20);
    mem_cal_fail = 6'h00;
    wait_mem(all_m, 40);
    cyc(5);
    mem_cal_success = all_m;
    drain(40);

    // 4: calibration never completes -> timeouts exhaust retries
    push(S_IDLE, 6'h00, 2'd0, -1, -1);
    pcie_npor       = 1'b0;
    mem_cal_success = 6'h00;
    drain(20);
    push(S_WPLL, 6'h00, 2'd0, -1, -1);
    push(S_MRST, 6'h00, 2'd0, 1, -1);
    push(S_WCAL, all_m, 2'd0, 16, -1);
    push(S_MRST, 6'h00, 2'd1, 100, -1);
    push(S_WCAL, all_m, 2'd1, 16, -1);
    push(S_MRST, 6'h00, 2'd2, 100, -1);
    push(S_WCAL, all_m, 2'd2, 16, -1);
    push(S_FAIL, 6'h00, 2'd2, 100, 8'h56);
    pcie_npor = 1'b1;
    drain(500);
    cyc(10);
    chk("fail_sticky_state", {28'd0, leds[3:0]}, {28'd0, S_FAIL});

    // 5: PLL loss while running, then relock and resequence
    push(S_IDLE, 6'h00, 2'd0, -1, -1);
    pcie_npor = 1'b0;
    drain(20);
    push(S_WPLL, 6'h00, 2'd0, -1, -1);
    push(S_MRST, 6'h00, 2'd0, 1, -1);
    push(S_WCAL, all_m, 2'd0, 16, -1);
    push(S_KDLY, all_m, 2'd0, -1, -1);
    push(S_RUN,  all_m, 2'd0, 8, 8'h65);
    pcie_npor = 1'b1;
    wait_mem(all_m, 60);
    cyc(3);
    mem_cal_success = all_m;
    drain(40);
    cyc(5);
    push(S_WPLL, 6'h00, 2'd0, -1, -1);
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pll_loss_krn", {31'd0, kernel_resetn}, 32'h0);
    chk("pll_loss_state", {28'd0, leds[3:0]}, {28'd0, S_WPLL});
    cyc(5);
    push(S_MRST, 6'h00, 2'd0, -1, -1);
    push(S_WCAL, all_m, 2'd0, 16, -1);
    push(S_KDLY, all_m, 2'd0, 1, -1);
    push(S_RUN,  all_m, 2'd0, 8, 8'h65);
    pll_locked = 1'b1;
    drain(60);

    // 6: async reset during calibration
    push(S_IDLE, 6'h00, 2'd0, -1, -1);
    pcie_npor       = 1'b0;
    mem_cal_success = 6'h00;
    drain(20);
    push(S_WPLL, 6'h00, 2'd0, -1, -1);
    push(S_MRST, 6'h00, 2'd0, 1, -1);
    push(S_WCAL, all_m, 2'd0, 16, -1);
    pcie_npor = 1'b1;
    wait_mem(all_m, 60);
    cyc(10);
    drain(5);
    push(S_IDLE, 6'h00, 2'd0, -1, -1);
    #3 resetn = 1'b0;
    #1;
    chk("arst_mem_n", {26'd0, mem_soft_reset_n}, 32'h0);
    chk("arst_krn", {31'd0, kernel_resetn}, 32'h0);
    chk("arst_leds", {24'd0, leds}, 32'h0);
    cyc(3);
    push(S_WPLL, 6'h00, 2'd0, -1, -1);
    push(S_MRST, 6'h00, 2'd0, 1, -1);
    push(S_WCAL, all_m, 2'd0, 16, -1);
    push(S_KDLY, all_m, 2'd0, -1, -1);
    push(S_RUN,  all_m, 2'd0, 8, 8'h65);
    resetn = 1'b1;
    wait_mem(all_m, 60);
    cyc(2);
    mem_cal_success = all_m;
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
